// File: rtl/tree_fanin_pkg.sv
// Shared types and round-robin helper for the tree fan-in collector.
package tree_fanin_pkg;

  localparam int MAX_CHILD  = 16;
  localparam int MAX_IDX_W  = 4;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  last;
    logic [MAX_IDX_W-1:0]  src;
  } beat_t;

  // Zero-padded requests make a mod-16 search equal to mod-NUM_CHILD.
  function automatic logic [MAX_CHILD-1:0] rr_next(
    input logic [MAX_CHILD-1:0] req,
    input logic [MAX_IDX_W-1:0] ptr
  );
    logic [MAX_CHILD-1:0] g;
    logic [MAX_IDX_W-1:0] idx;
    g = '0;
    for (int k = 1; k <= MAX_CHILD; k++) begin
      idx = ptr + MAX_IDX_W'(k);
      if (req[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/tree_fanin_rr_arb.sv
// Round-robin arbiter owning the priority pointer and packet lock.
// Packet lock is built only with TREE_FANIN_PKT_LOCK_EN defined.
module tree_fanin_rr_arb
  import tree_fanin_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          lock_i,
  input  logic          upd_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [MAX_CHILD-1:0] req_pad, rr_pad;
  logic [MAX_IDX_W-1:0] ptr_pad;
  logic                 unused_arb;

  assign unused_arb = ^{rr_pad, lock_i, lock_q};

  always_comb begin
    req_pad = '0;
    req_pad[N-1:0] = req_i;
    ptr_pad = '0;
    ptr_pad[IW-1:0] = ptr_q;
    rr_pad = rr_next(req_pad, ptr_pad);
  end

  always_comb begin
    grant_o = rr_pad[N-1:0];
`ifdef TREE_FANIN_PKT_LOCK_EN
    // While locked ptr_q holds the owning child.
    if (lock_q) begin
      grant_o = '0;
      grant_o[ptr_q] = req_i[ptr_q];
    end
`endif
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (grant_o[i]) idx_o = IW'(i);
  end

  always_comb begin
    ptr_d = upd_i ? idx_o : ptr_q;
`ifdef TREE_FANIN_PKT_LOCK_EN
    lock_d = upd_i ? lock_i : lock_q;
`else
    lock_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= IW'(N - 1);
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/tree_fanin_collector.sv
// Merges NUM_CHILD upward streams into one registered stream.
// Optional packet lock: define TREE_FANIN_PKT_LOCK_EN.
module tree_fanin_collector
  import tree_fanin_pkg::*;
#(
  parameter  int NUM_CHILD = 5,
  parameter  int DATA_W    = 32,
  localparam int SRC_W     = $clog2(NUM_CHILD)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHILD-1:0]             child_valid,
  output logic [NUM_CHILD-1:0]             child_ready,
  input  logic [NUM_CHILD-1:0][DATA_W-1:0] child_data,
  input  logic [NUM_CHILD-1:0]             child_last,
  output logic                             up_valid,
  input  logic                             up_ready,
  output logic [DATA_W-1:0]                up_data,
  output logic                             up_last,
  output logic [SRC_W-1:0]                 up_src
);

  logic                 load_en, xfer;
  logic [NUM_CHILD-1:0] grant;
  logic [SRC_W-1:0]     gidx;
  logic                 vld_q, vld_d;
  beat_t                beat_q, beat_d;
  logic                 unused_beat;

  assign load_en     = !vld_q || up_ready;
  assign child_ready = (load_en && !rst) ? grant : '0;
  assign xfer        = |child_ready;

  tree_fanin_rr_arb #(
    .N  (NUM_CHILD),
    .IW (SRC_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (child_valid),
    .lock_i  (!child_last[gidx]),
    .upd_i   (xfer),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  always_comb begin
    beat_d = beat_q;
    vld_d  = vld_q;
    if (xfer) begin
      beat_d = '0;
      beat_d.data[DATA_W-1:0] = child_data[gidx];
      beat_d.last = child_last[gidx];
      beat_d.src[SRC_W-1:0] = gidx;
      vld_d = 1'b1;
    end else if (up_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      vld_q  <= vld_d;
    end
  end

  assign up_valid    = vld_q;
  assign up_data     = beat_q.data[DATA_W-1:0];
  assign up_last     = beat_q.last;
  assign up_src      = beat_q.src[SRC_W-1:0];
  assign unused_beat = ^beat_q;

endmodule

// File: tb/tb_tree_fanin_collector.sv
// Directed self-checking bench for tree_fanin_collector.
module tb_tree_fanin_collector;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      cv, cr, cl;
  logic [4:0][31:0] cd;
  logic            uv, ur, ul;
  logic [31:0]     ud;
  logic [2:0]      us;
  int              n_chk = 0;
  int              n_pass = 0;

  always #5 clk = ~clk;

  tree_fanin_collector dut (
    .clk         (clk),
    .rst         (rst),
    .child_valid (cv),
    .child_ready (cr),
    .child_data  (cd),
    .child_last  (cl),
    .up_valid    (uv),
    .up_ready    (ur),
    .up_data     (ud),
    .up_last     (ul),
    .up_src      (us)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int c0n;
    logic [4:0] r;
    int wrap_exp[3];
    int lk_src[5];
    int lk_last[5];
    wrap_exp = '{1, 3, 1};
`ifdef TREE_FANIN_PKT_LOCK_EN
    lk_src  = '{0, 0, 0, 1, 1};
    lk_last = '{0, 0, 1, 1, 1};
`else
    lk_src  = '{0, 1, 0, 1, 0};
    lk_last = '{0, 1, 0, 1, 1};
`endif
    rst = 1'b1; cv = '0; cl = '0; cd = '0; ur = 1'b1;
    tick();
    cv = 5'h1f;
    #1;
    check("rst_ready", 32'(cr), 32'h0);
    check("rst_valid", 32'(uv), 32'h0);
    check("rst_data", ud, 32'h0);
    check("rst_src", 32'(us), 32'h0);
    check("rst_last", 32'(ul), 32'h0);

    // round-robin fairness
    for (int i = 0; i < 5; i++) cd[i] = 32'h100 + i;
    cl = 5'h1f;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("rr_ready", 32'(cr), 32'(1 << (k % 5)));
      tick();
      check("rr_valid", 32'(uv), 32'h1);
      check("rr_src", 32'(us), 32'(k % 5));
      check("rr_data", ud, 32'h100 + 32'(k % 5));
    end

    // idle: drain, pointer stays at child 1
    cv = '0;
    #1;
    check("idle_ready", 32'(cr), 32'h0);
    tick();
    check("idle_drain", 32'(uv), 32'h0);
    tick();
    check("idle_hold", 32'(uv), 32'h0);
    cv = 5'b10101;
    #1;
    check("idle_ptr", 32'(cr), 32'b00100);
    tick();
    check("idle_src", 32'(us), 32'd2);
    cv = 5'b10000;
    #1;
    check("to4_ready", 32'(cr), 32'b10000);
    tick();
    check("to4_src", 32'(us), 32'd4);

    // wrap-around from ptr=4
    cv = 5'b01010;
    for (int j = 0; j < 3; j++) begin
      e = wrap_exp[j];
      #1;
      check("wrap_ready", 32'(cr), 32'(1 << e));
      tick();
      check("wrap_src", 32'(us), 32'(e));
    end
    cv = '0;
    tick();

    // back-pressure
    ur = 1'b0;
    cv = 5'b00100;
    cd[2] = 32'hA5A5_0001;
    #1;
    check("bp_first", 32'(cr), 32'b00100);
    tick();
    cd[2] = 32'hA5A5_0002;
    for (int i = 0; i < 3; i++) begin
      check("bp_data", ud, 32'hA5A5_0001);
      check("bp_valid", 32'(uv), 32'h1);
      #1;
      check("bp_ready", 32'(cr), 32'h0);
      tick();
    end
    ur = 1'b1;
    #1;
    check("bp_release", 32'(cr), 32'b00100);
    tick();
    check("bp_once", ud, 32'hA5A5_0002);
    cv = '0;
    tick();
    check("bp_drain", 32'(uv), 32'h0);

    // packet lock / interleave
    c0n = 0;
    cd[1] = 32'hC1;
    cl[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cv[0] = (c0n < 3);
      cd[0] = 32'hC0 + 32'(c0n);
      cl[0] = (c0n == 2);
      cv[1] = 1'b1;
      #1;
      r = cr;
      tick();
      if (r[0]) c0n++;
      check("lock_src", 32'(us), 32'(lk_src[k]));
      check("lock_last", 32'(ul), 32'(lk_last[k]));
    end

    // reset mid-operation
    cv = '0;
    tick();
    cv = 5'b00001;
    cd[0] = 32'hDEAD_BEEF;
    cl[0] = 1'b1;
    tick();
    cv = '0;
    check("mid_data", ud, 32'hDEAD_BEEF);
    check("mid_valid", 32'(uv), 32'h1);
    ur = 1'b0;
    rst = 1'b1;
    cv = 5'h1f;
    #1;
    check("mid_rst_ready", 32'(cr), 32'h0);
    tick();
    check("mid_rst_valid", 32'(uv), 32'h0);
    check("mid_rst_data", ud, 32'h0);
    rst = 1'b0;
    ur = 1'b1;
    #1;
    check("mid_first", 32'(cr), 32'b00001);
    tick();
    check("mid_src", 32'(us), 32'd0);
    cv = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
